// File: rtl/useq_pkg.sv
// Shared definitions for the microsequencer: control-word field positions,
// next-state (N) encodings and condition-select (S) encodings.
package useq_pkg;

  // Control-word field positions
  localparam int unsigned N_HI    = 57;
  localparam int unsigned N_LO    = 55;
  localparam int unsigned INV_BIT = 54;
  localparam int unsigned S_HI    = 52;
  localparam int unsigned S_LO    = 50;
  localparam int unsigned T_HI    = 41;
  localparam int unsigned T_LO    = 34;

  // Next-state field encodings
  typedef enum logic [2:0] {
    NS_ZERO     = 3'b000,
    NS_ENC      = 3'b001,
    NS_JMP      = 3'b010,
    NS_WAIT     = 3'b011,
    NS_CJMP     = 3'b100,
    NS_CJMP_ENC = 3'b101,
    NS_CENC     = 3'b110,
    NS_INC      = 3'b111
  } nsel_e;

  // Condition-select field encodings
  typedef enum logic [2:0] {
    CS_MOC   = 3'b000,
    CS_COND  = 3'b001,
    CS_Z     = 3'b010,
    CS_N     = 3'b011,
    CS_C     = 3'b100,
    CS_V     = 3'b101,
    CS_TRUE  = 3'b110,
    CS_FALSE = 3'b111
  } csel_e;

endpackage

// File: rtl/useq_next_addr.sv
// Combinational next-address logic: condition mux with inversion,
// state incrementer and next-address selection from the N field.
// hold_o flags a wait-state hold (N=011 with cond=0) for the watchdog.
module useq_next_addr
  import useq_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 64
) (
  input  logic [WORD_W-1:0] ctrl_word_i,
  input  logic [ADDR_W-1:0] state_i,
  input  logic [ADDR_W-1:0] encoder_addr_i,
  input  logic              moc_i,
  input  logic              cond_pass_i,
  input  logic [3:0]        flags_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              hold_o
);

  nsel_e             nsel;
  csel_e             csel;
  logic              inv;
  logic              sel;
  logic              cond;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] incr;

  assign nsel = nsel_e'(ctrl_word_i[N_HI:N_LO]);
  assign csel = csel_e'(ctrl_word_i[S_HI:S_LO]);
  assign inv  = ctrl_word_i[INV_BIT];
  assign tgt  = ADDR_W'(ctrl_word_i[T_HI:T_LO]);
  assign incr = state_i + ADDR_W'(1);

  // Condition source select; flags are {N,Z,C,V}
  always_comb begin
    sel = 1'b0;
    case (csel)
      CS_MOC:   sel = moc_i;
      CS_COND:  sel = cond_pass_i;
      CS_Z:     sel = flags_i[2];
      CS_N:     sel = flags_i[3];
      CS_C:     sel = flags_i[1];
      CS_V:     sel = flags_i[0];
      CS_TRUE:  sel = 1'b1;
      CS_FALSE: sel = 1'b0;
      default:  sel = 1'b0;
    endcase
  end

  assign cond = sel ^ inv;

  // Next-address selection by N field
  always_comb begin
    next_addr_o = '0;
    hold_o      = 1'b0;
    case (nsel)
      NS_ZERO:     next_addr_o = '0;
      NS_ENC:      next_addr_o = encoder_addr_i;
      NS_JMP:      next_addr_o = tgt;
      NS_WAIT: begin
        next_addr_o = cond ? incr : state_i;
        hold_o      = ~cond;
      end
      NS_CJMP:     next_addr_o = cond ? tgt : incr;
      NS_CJMP_ENC: next_addr_o = cond ? tgt : encoder_addr_i;
      NS_CENC:     next_addr_o = cond ? encoder_addr_i : tgt;
      NS_INC:      next_addr_o = incr;
      default:     next_addr_o = '0;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microprogram sequencer: drives the ROM address combinationally, latches the
// returned word as the executing control word and runs a memory-wait watchdog
// that aborts to state 0 after WAIT_MAX consecutive hold cycles.
// Optional macro USEQ_STALL_EN adds a stall input that freezes the sequencer.
module microsequencer
  import useq_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_word,
  output logic [WORD_W-1:0] ctrl_word,
  output logic [ADDR_W-1:0] state,
  input  logic [ADDR_W-1:0] encoder_addr,
  input  logic              moc,
  input  logic              cond_pass,
  input  logic [3:0]        flags,
  output logic              mem_timeout
`ifdef USEQ_STALL_EN
  ,
  input  logic              stall
`endif
);

  logic [ADDR_W-1:0] state_q;
  logic [WORD_W-1:0] ctrl_q;
  logic [7:0]        wait_q;
  logic [7:0]        wait_d;
  logic              timeout_q;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] addr_d;
  logic              hold;
  logic              abort;
  logic              stall_w;

`ifdef USEQ_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  useq_next_addr #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_next_addr (
    .ctrl_word_i    (ctrl_q),
    .state_i        (state_q),
    .encoder_addr_i (encoder_addr),
    .moc_i          (moc),
    .cond_pass_i    (cond_pass),
    .flags_i        (flags),
    .next_addr_o    (next_addr),
    .hold_o         (hold)
  );

  // Watchdog: count consecutive holds, abort to 0 once the limit is reached
  always_comb begin
    abort  = hold && (wait_q == 8'(WAIT_MAX));
    wait_d = '0;
    if (hold && !abort) wait_d = wait_q + 8'd1;
    addr_d = abort ? '0 : next_addr;
  end

  // During stall the ROM re-reads the current state so its output matches ctrl_word
  assign rom_addr = stall_w ? state_q : addr_d;

  // Sequencer registers; stall freezes everything except the timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= '0;
      ctrl_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (stall_w) begin
      timeout_q <= 1'b0;
    end else begin
      state_q   <= addr_d;
      ctrl_q    <= rom_word;
      wait_q    <= wait_d;
      timeout_q <= abort;
    end
  end

  assign state       = state_q;
  assign ctrl_word   = ctrl_q;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer (WAIT_MAX=4) with a behavioural ROM.
module tb_microsequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_addr;
  logic [63:0] rom_word;
  logic [63:0] ctrl_word;
  logic [7:0]  state;
  logic [7:0]  encoder_addr;
  logic        moc;
  logic        cond_pass;
  logic [3:0]  flags;
  logic        mem_timeout;
  logic        stall;

  logic [63:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb rom_word = rom[rom_addr];

  microsequencer #(
    .ADDR_W   (8),
    .WORD_W   (64),
    .WAIT_MAX (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr     (rom_addr),
    .rom_word     (rom_word),
    .ctrl_word    (ctrl_word),
    .state        (state),
    .encoder_addr (encoder_addr),
    .moc          (moc),
    .cond_pass    (cond_pass),
    .flags        (flags),
    .mem_timeout  (mem_timeout)
`ifdef USEQ_STALL_EN
    ,
    .stall        (stall)
`endif
  );

  typedef struct {
    logic [7:0]  start;
    logic [63:0] word;
    logic        moc;
    logic        cp;
    logic [3:0]  flags;
    logic [7:0]  enc;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [63:0] mk(logic [2:0] n, logic inv, logic [2:0] s, logic [7:0] t);
    logic [63:0] w;
    w = '0;
    w[57:55] = n;
    w[54]    = inv;
    w[52:50] = s;
    w[41:34] = t;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Reset, then word 0 jumps via the encoder to 'start', leaving ROM(start) executing
  task automatic setup(logic [7:0] start);
    reset = 1'b1;
    stall = 1'b0;
    tick();
    reset = 1'b0;
    encoder_addr = start;
    rom[0] = mk(3'b001, 1'b0, 3'b000, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mk(3'b111, 1'b0, 3'b000, 8'h00) | 64'(i);
    reset = 1'b1; stall = 1'b0; moc = 1'b0; cond_pass = 1'b0; flags = 4'h0; encoder_addr = 8'h00;

    // Reset state and first fetch
    tick(); tick();
    check("rst_state", 64'(state), 64'h0);
    check("rst_ctrl", ctrl_word, 64'h0);
    check("rst_romaddr", 64'(rom_addr), 64'h0);
    check("rst_timeout", 64'(mem_timeout), 64'h0);
    reset = 1'b0;
    tick();
    check("first_state", 64'(state), 64'h0);
    check("first_ctrl", ctrl_word, rom[0]);
    check("first_romaddr", 64'(rom_addr), 64'h1);

    // Table-driven single-step vectors
    vecs[0]  = '{8'd5,   mk(3'b111,0,3'b000,8'h00), 0,0,4'b0000, 8'h00, 8'd6};
    vecs[1]  = '{8'd255, mk(3'b111,0,3'b000,8'h00), 0,0,4'b0000, 8'h00, 8'd0};
    vecs[2]  = '{8'd16,  mk(3'b100,1,3'b010,8'h2A), 0,0,4'b0000, 8'h00, 8'h2A};
    vecs[3]  = '{8'd16,  mk(3'b100,1,3'b010,8'h2A), 0,0,4'b0100, 8'h00, 8'd17};
    vecs[4]  = '{8'd7,   mk(3'b001,0,3'b000,8'h00), 0,0,4'b0000, 8'h0A, 8'h0A};
    vecs[5]  = '{8'd9,   mk(3'b000,0,3'b110,8'h77), 1,1,4'b1111, 8'h55, 8'd0};
    vecs[6]  = '{8'd9,   mk(3'b010,0,3'b111,8'h33), 0,0,4'b0000, 8'h55, 8'h33};
    vecs[7]  = '{8'd20,  mk(3'b011,0,3'b001,8'h00), 0,1,4'b0000, 8'h00, 8'd21};
    vecs[8]  = '{8'd20,  mk(3'b011,0,3'b001,8'h00), 1,0,4'b0000, 8'h00, 8'd20};
    vecs[9]  = '{8'd30,  mk(3'b101,0,3'b110,8'h40), 0,0,4'b0000, 8'h66, 8'h40};
    vecs[10] = '{8'd30,  mk(3'b101,0,3'b111,8'h40), 0,0,4'b0000, 8'h66, 8'h66};
    vecs[11] = '{8'd40,  mk(3'b110,0,3'b011,8'h50), 0,0,4'b1000, 8'h77, 8'h77};
    vecs[12] = '{8'd40,  mk(3'b110,0,3'b011,8'h50), 0,0,4'b0111, 8'h77, 8'h50};
    vecs[13] = '{8'd50,  mk(3'b100,0,3'b100,8'h60), 0,0,4'b0010, 8'h00, 8'h60};
    vecs[14] = '{8'd50,  mk(3'b100,0,3'b101,8'h60), 0,0,4'b1110, 8'h00, 8'd51};
    vecs[15] = '{8'd60,  mk(3'b011,1,3'b000,8'h00), 1,0,4'b0000, 8'h00, 8'd60};

    for (int i = 0; i < 16; i++) begin
      rom[vecs[i].start] = vecs[i].word;
      setup(vecs[i].start);
      moc = vecs[i].moc; cond_pass = vecs[i].cp; flags = vecs[i].flags;
      encoder_addr = vecs[i].enc;
      #1;
      check($sformatf("vec%0d_romaddr", i), 64'(rom_addr), 64'(vecs[i].exp));
      tick();
      check($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].exp));
      check($sformatf("vec%0d_ctrl", i), ctrl_word, rom[vecs[i].exp]);
      check($sformatf("vec%0d_timeout", i), 64'(mem_timeout), 64'h0);
    end
    flags = 4'h0; cond_pass = 1'b0;

    // MOC wait at 3 released after 3 holds, then watchdog abort at 4 (counter restarted)
    rom[3] = mk(3'b011, 1'b0, 3'b000, 8'h00);
    rom[4] = mk(3'b011, 1'b0, 3'b000, 8'h00);
    moc = 1'b0;
    setup(8'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("wait3_state%0d", k), 64'(state), 64'd3);
    end
    moc = 1'b1;
    #1;
    check("wait3_release_addr", 64'(rom_addr), 64'd4);
    tick();
    check("wait3_release_state", 64'(state), 64'd4);
    moc = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("wd4_state%0d", k), 64'(state), 64'd4);
      check($sformatf("wd4_timeout%0d", k), 64'(mem_timeout), 64'h0);
    end
    #1;
    check("wd4_abort_addr", 64'(rom_addr), 64'h0);
    tick();
    check("wd4_abort_state", 64'(state), 64'h0);
    check("wd4_pulse", 64'(mem_timeout), 64'h1);
    tick();
    check("wd4_pulse_end", 64'(mem_timeout), 64'h0);

    // Reset mid-wait clears the counter: full 4 holds available afterwards
    setup(8'd3);
    tick(); tick();
    reset = 1'b1;
    tick();
    check("midrst_state", 64'(state), 64'h0);
    check("midrst_ctrl", ctrl_word, 64'h0);
    reset = 1'b0;
    tick(); tick();
    check("midrst_reenter", 64'(state), 64'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("midrst_hold%0d", k), 64'(state), 64'd3);
      check($sformatf("midrst_to%0d", k), 64'(mem_timeout), 64'h0);
    end
    tick();
    check("midrst_abort", 64'(state), 64'h0);
    check("midrst_pulse", 64'(mem_timeout), 64'h1);

`ifdef USEQ_STALL_EN
    // Stall freezes the wait without advancing the watchdog
    setup(8'd3);
    tick();
    stall = 1'b1;
    #1;
    check("stall_romaddr", 64'(rom_addr), 64'd3);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_state%0d", k), 64'(state), 64'd3);
      check($sformatf("stall_ctrl%0d", k), ctrl_word, rom[3]);
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_post%0d", k), 64'(state), 64'd3);
      check($sformatf("stall_post_to%0d", k), 64'(mem_timeout), 64'h0);
    end
    tick();
    check("stall_abort", 64'(state), 64'h0);
    check("stall_pulse", 64'(mem_timeout), 64'h1);
    stall = 1'b1;
    tick();
    check("stall_pulse_clr", 64'(mem_timeout), 64'h0);
    check("stall_hold0", 64'(state), 64'h0);
    setup(8'd9);
    stall = 1'b1; reset = 1'b1;
    tick();
    check("stallrst_state", 64'(state), 64'h0);
    check("stallrst_ctrl", ctrl_word, 64'h0);
    stall = 1'b0; reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
